display_panel_capture: RTL and testbench
========================================

// Module: display_panel_capture
// PURPOSE
//  Panel-side receiver for the RGB shift-chain interface: samples panel clock, rgb, latch and
//  row address, rebuilds the per-column bit planes and reassembles full pixels per row. Serves
//  as loopback/self-check sink and panel model behind the display driver. Outputs pixels on a
//  valid/ready stream, one column per beat.
// PARAMETERS
//  segments   1  parallel rgb triplets (panel halves); out_pixel carries all segments
//  bitwidth   8  bits per colour channel = number of bit planes per row
//  columns    8  shift-chain length per row
//  row_bits   4  row address width
// PORTS
//  clk          in   1                    system clock, all logic on rising edge
//  rst          in   1                    synchronous, active-low reset
//  panel_clk    in   1                    panel shift clock, synchronous to clk, high/low >=1 clk each
//  panel_rgb    in   3*segments           shift data {b,g,r} per segment, segment 0 in LSBs
//  panel_latch  in   1                    latch strobe, rising edge ends a bit plane
//  panel_addr   in   row_bits             row address, stable at latch rise
//  out_valid    out  1                    pixel beat valid
//  out_ready    in   1                    sink accepts beat when valid&&ready
//  out_pixel    out  3*bitwidth*segments  {b,g,r} per segment, segment 0 in LSBs
//  out_column   out  $clog2(columns)      column of current beat
//  out_row      out  row_bits             row of current beat
//  overflow     out  1                    sticky: row completed while previous row still draining
//  sync_err     out  1                    sticky: plane sequence broken (see below)
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): out_valid=0, out_pixel/out_column/out_row=0, overflow=0,
//    sync_err=0, plane counter=0, shift count=0, edge registers=0; mid-drain row is discarded.
//  - Edge detect: registered copies of panel_clk/panel_latch; rise = now&&!prev. panel_rgb
//    sampled in the clk cycle the panel_clk rise is detected.
//  - Shift: each panel_clk rise shifts panel_rgb into a columns-deep chain per segment/channel;
//    first bit shifted after a latch = column 0 at latch time (chain order preserved).
//  - Latch rise: chain copied into bit k (k = plane counter) of every channel of the row
//    assembly buffer; shift count cleared; plane counter +1. Latch on same cycle as clk rise:
//    the shift completes first, then the copy includes it.
//  - Row address: captured at plane 0 latch. Latch at plane k>0 with different panel_addr:
//    sync_err=1, partial row dropped, this latch treated as plane 0 of the new row.
//  - Row complete: latch of plane bitwidth-1 -> plane counter wraps to 0; if drain FSM IDLE the
//    buffer transfers to the output stage and out_valid=1 on the next clk (1-cycle latency);
//    otherwise overflow=1 and the new row is discarded (draining row unaffected).
//  - Drain FSM: IDLE -> SEND on row complete; SEND holds out_pixel/out_column/out_row stable
//    while out_valid&&!out_ready; each accepted beat increments out_column; accept at column
//    columns-1 -> IDLE, out_valid=0 same edge. Assembly of the next row continues during SEND.
//  - Width rules: plane counter $clog2(bitwidth) bits, wraps at bitwidth (not power of two);
//    shift count saturates at columns.
// CONFIGURATION
//  DISPLAY_PANEL_CAPTURE_LENGTH_CHECK_EN defined: latch rise with shift count != columns sets
//    sync_err=1; plane still written (short chain = stale bits kept in unshifted positions).
//  Not defined: shift count logic removed; sync_err only from address mismatch.
// STRUCTURE
//  - display_defines.vh: shared `define for {b,g,r} channel ordering/offsets and pixel slice
//    macros used by both this block and display_driver_rgb_pipe.
//  - Sub-module display_capture_shift: one segment's 3-channel columns-deep shift chain with
//    shift enable and parallel read; instantiated segments times.
//  - Top: edge detect, plane/row tracking, assembly buffer, drain FSM, error flags.
// TESTING
//  1 Reset: hold rst=0 3 clk with toggling inputs -> out_valid=0, overflow=0, sync_err=0.
//  2 Single row, segments=1, columns=8: shift 8 planes, column c bit k = (c==k), addr=3 ->
//    8 beats, out_pixel column c = {3{8'h01<<c}}, out_row=3, columns 0..7 in order.
//  3 Backpressure: scenario 2 with out_ready low 3 cycles mid-row -> beat held stable,
//    no column skipped or repeated, exactly 8 accepts.
//  4 Overflow: out_ready=0, complete two rows -> overflow=1 after second, first row then drains
//    intact with out_row of first row.
//  5 Address change: latch plane 0..2 at addr 1, plane 3 latch at addr 2 -> sync_err=1; next 7
//    latches at addr 2 complete row, out_row=2.
//  6 With LENGTH_CHECK_EN: latch after 7 shifts -> sync_err=1; without macro -> sync_err stays 0.

Source files
------------

// File: rtl/display_panel_capture_pkg.sv
// Shared types and helpers for the panel-side RGB shift-chain capture block.
// Pixel layout: {b,g,r} per segment, segment 0 in the LSBs, bit plane k at bit k of a channel.
package display_panel_capture_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_SEND
  } drain_state_e;

  // Width helper that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit position of plane k of channel ch (0=r, 1=g, 2=b) of segment seg inside a pixel word.
  function automatic int pix_bit(input int seg, input int ch, input int k, input int bw);
    return (seg * NUM_CH + ch) * bw + k;
  endfunction

endpackage

// File: rtl/display_panel_capture_if.sv
// Panel shift-chain inputs plus the pixel valid/ready output stream of the capture block.
// slave = capture block side, master = panel driver / pixel sink side.
interface display_panel_capture_if #(
  parameter int segments = 1,
  parameter int bitwidth = 8,
  parameter int columns  = 8,
  parameter int row_bits = 4
);
  import display_panel_capture_pkg::*;

  localparam int COL_W = clog2_min1(columns);

  logic                               panel_clk;
  logic [NUM_CH*segments-1:0]         panel_rgb;
  logic                               panel_latch;
  logic [row_bits-1:0]                panel_addr;
  logic                               out_valid;
  logic                               out_ready;
  logic [NUM_CH*bitwidth*segments-1:0] out_pixel;
  logic [COL_W-1:0]                   out_column;
  logic [row_bits-1:0]                out_row;

  modport slave (
    input  panel_clk, panel_rgb, panel_latch, panel_addr, out_ready,
    output out_valid, out_pixel, out_column, out_row
  );

  modport master (
    output panel_clk, panel_rgb, panel_latch, panel_addr, out_ready,
    input  out_valid, out_pixel, out_column, out_row
  );

endinterface

// File: rtl/display_capture_shift.sv
// One segment's {b,g,r} shift chains, columns deep. chain_o already includes this cycle's
// shift so a latch arriving with a shift edge copies the freshly shifted bit.
module display_capture_shift
  import display_panel_capture_pkg::*;
#(
  parameter int columns = 8
) (
  input  logic                           clk,
  input  logic                           shift_en_i,
  input  logic [NUM_CH-1:0]              rgb_i,
  output logic [NUM_CH-1:0][columns-1:0] chain_o
);

  logic [NUM_CH-1:0][columns-1:0] chain_q, chain_d;

  // New bits enter at the top so the first bit after a latch ends up in column 0.
  always_comb begin
    chain_d = chain_q;
    if (shift_en_i) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        chain_d[ch]            = chain_q[ch] >> 1;
        chain_d[ch][columns-1] = rgb_i[ch];
      end
    end
  end

  always_ff @(posedge clk) begin
    chain_q <= chain_d;
  end

  assign chain_o = chain_d;

endmodule

// File: rtl/display_panel_capture.sv
// Panel-side receiver: rebuilds bit planes from the RGB shift chain, assembles rows and drains
// them as one pixel beat per column. Optional DISPLAY_PANEL_CAPTURE_LENGTH_CHECK_EN flags short chains.
module display_panel_capture
  import display_panel_capture_pkg::*;
#(
  parameter int segments = 1,
  parameter int bitwidth = 8,
  parameter int columns  = 8,
  parameter int row_bits = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  display_panel_capture_if.slave bus,
  output logic                   overflow,
  output logic                   sync_err
);

  localparam int PIX_W = NUM_CH * bitwidth * segments;
  localparam int COL_W = clog2_min1(columns);
  localparam int PL_W  = clog2_min1(bitwidth);

  logic pclk_q, latch_q;
  logic shift_en, latch_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pclk_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      pclk_q  <= bus.panel_clk;
      latch_q <= bus.panel_latch;
    end
  end

  assign shift_en   = bus.panel_clk && !pclk_q;
  assign latch_rise = bus.panel_latch && !latch_q;

  logic [segments-1:0][NUM_CH-1:0][columns-1:0] chain;

  for (genvar s = 0; s < segments; s++) begin : g_seg
    display_capture_shift #(
      .columns(columns)
    ) u_shift (
      .clk       (clk),
      .shift_en_i(shift_en),
      .rgb_i     (bus.panel_rgb[s*NUM_CH +: NUM_CH]),
      .chain_o   (chain[s])
    );
  end

  logic [PL_W-1:0]     plane_q, plane_d, plane_eff;
  logic [row_bits-1:0] row_q, row_d, row_eff;
  logic                addr_mismatch, last_plane, row_done;

  // An address change mid-row restarts assembly: this latch becomes plane 0 of the new row.
  always_comb begin
    addr_mismatch = latch_rise && (plane_q != '0) && (bus.panel_addr != row_q);
    plane_eff     = addr_mismatch ? '0 : plane_q;
    row_eff       = (plane_eff == '0) ? bus.panel_addr : row_q;
    last_plane    = (plane_eff == PL_W'(bitwidth - 1));
    row_done      = latch_rise && last_plane;
    plane_d       = plane_q;
    row_d         = row_q;
    if (latch_rise) begin
      plane_d = last_plane ? '0 : plane_eff + 1'b1;
      row_d   = row_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      plane_q <= '0;
      row_q   <= '0;
    end else begin
      plane_q <= plane_d;
      row_q   <= row_d;
    end
  end

  logic [columns-1:0][PIX_W-1:0] asm_q, asm_d;

  always_comb begin
    asm_d = asm_q;
    if (latch_rise) begin
      for (int c = 0; c < columns; c++)
        for (int s = 0; s < segments; s++)
          for (int ch = 0; ch < NUM_CH; ch++)
            for (int k = 0; k < bitwidth; k++)
              if (plane_eff == PL_W'(k))
                asm_d[c][pix_bit(s, ch, k, bitwidth)] = chain[s][ch][c];
    end
  end

  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  logic len_err;

`ifdef DISPLAY_PANEL_CAPTURE_LENGTH_CHECK_EN
  localparam int CNT_W = $clog2(columns + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;

  // Count includes a shift arriving in the latch cycle; saturates at a full chain.
  always_comb begin
    cnt_eff = (shift_en && (cnt_q != CNT_W'(columns))) ? cnt_q + 1'b1 : cnt_q;
    cnt_d   = latch_rise ? '0 : cnt_eff;
    len_err = latch_rise && (cnt_eff != CNT_W'(columns));
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign len_err = 1'b0;
`endif

  drain_state_e        state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [row_bits-1:0] orow_q, orow_d;
  logic [columns-1:0][PIX_W-1:0] obuf_q;
  logic                load, ovf_set;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    orow_d  = orow_q;
    load    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (row_done) begin
          state_d = DRAIN_SEND;
          col_d   = '0;
          orow_d  = row_eff;
          load    = 1'b1;
        end
      end
      DRAIN_SEND: begin
        ovf_set = row_done;
        if (bus.out_ready) begin
          if (col_q == COL_W'(columns - 1)) begin
            state_d = DRAIN_IDLE;
            col_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DRAIN_IDLE;
      col_q   <= '0;
      orow_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      orow_q  <= orow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) obuf_q <= asm_d;
  end

  logic overflow_q, sync_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | ovf_set;
      sync_err_q <= sync_err_q | addr_mismatch | len_err;
    end
  end

  assign bus.out_valid  = (state_q == DRAIN_SEND);
  assign bus.out_pixel  = bus.out_valid ? obuf_q[col_q] : '0;
  assign bus.out_column = col_q;
  assign bus.out_row    = orow_q;
  assign overflow       = overflow_q;
  assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_display_panel_capture.sv
// Directed bench for display_panel_capture (segments=1, bitwidth=8, columns=8, row_bits=4).
module tb_display_panel_capture;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic overflow, sync_err;

  display_panel_capture_if #(.segments(1), .bitwidth(8), .columns(8), .row_bits(4)) bus ();

  display_panel_capture #(
    .segments(1), .bitwidth(8), .columns(8), .row_bits(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .overflow(overflow),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [23:0] exp_pix [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic [2:0] rgb);
    bus.panel_rgb = rgb;
    bus.panel_clk = 1'b1;
    tick();
    bus.panel_clk = 1'b0;
    tick();
  endtask

  // Shifts nshift columns (column hot carries 1 on all channels), then pulses latch for one clk.
  task automatic send_plane(input int hot, input logic [3:0] addr, input int nshift);
    for (int c = 0; c < nshift; c++) shift_bit((c == hot) ? 3'b111 : 3'b000);
    bus.panel_addr  = addr;
    bus.panel_latch = 1'b1;
    tick();
    bus.panel_latch = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.panel_clk   = ~bus.panel_clk;
      bus.panel_latch = ~bus.panel_latch;
      bus.panel_rgb   = 3'($urandom);
      bus.panel_addr  = 4'($urandom);
      bus.out_ready   = 1'b1;
      tick();
    end
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_sync_err", 32'(sync_err), 0);
    check("rst_pixel", 32'(bus.out_pixel), 0);
    check("rst_column", 32'(bus.out_column), 0);
    check("rst_row", 32'(bus.out_row), 0);
    bus.panel_clk   = 1'b0;
    bus.panel_latch = 1'b0;
    bus.panel_rgb   = '0;
    bus.panel_addr  = '0;
    bus.out_ready   = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic set_diag_pixels();
    logic [7:0] b;
    for (int c = 0; c < 8; c++) begin
      b = 8'h01 << c;
      exp_pix[c] = {b, b, b};
    end
  endtask

  // Drains one row; holds out_ready low for 3 cycles when beat stall_at is presented.
  task automatic drain(input logic [3:0] exp_row, input int stall_at);
    int beats  = 0;
    int cyc    = 0;
    int stalls = 0;
    while (beats < 8 && cyc < 100) begin
      if (beats == stall_at && stalls < 3) begin
        bus.out_ready = 1'b0;
        stalls++;
        check("hold_valid", 32'(bus.out_valid), 1);
        check("hold_column", 32'(bus.out_column), 32'(beats));
        check("hold_pixel", 32'(bus.out_pixel), 32'(exp_pix[beats]));
      end else begin
        bus.out_ready = 1'b1;
        if (bus.out_valid) begin
          check("beat_column", 32'(bus.out_column), 32'(beats));
          check("beat_pixel", 32'(bus.out_pixel), 32'(exp_pix[beats]));
          check("beat_row", 32'(bus.out_row), 32'(exp_row));
          beats++;
        end
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("beat_count", 32'(beats), 8);
    check("idle_after_row", 32'(bus.out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.panel_clk   = 1'b0;
    bus.panel_latch = 1'b0;
    bus.panel_rgb   = '0;
    bus.panel_addr  = '0;
    bus.out_ready   = 1'b0;

    // Reset with toggling inputs
    do_reset();

    // Single diagonal row at address 3
    set_diag_pixels();
    for (int k = 0; k < 8; k++) begin
      send_plane(k, 4'd3, 8);
      if (k == 6) check("valid_before_last_plane", 32'(bus.out_valid), 0);
    end
    check("valid_one_cycle_after_row", 32'(bus.out_valid), 1);
    check("first_beat_row", 32'(bus.out_row), 3);
    drain(4'd3, -1);
    check("no_sync_err_clean_row", 32'(sync_err), 0);
    check("no_overflow_single_row", 32'(overflow), 0);

    // Same row with backpressure at column 3
    for (int k = 0; k < 8; k++) send_plane(k, 4'd3, 8);
    drain(4'd3, 3);

    // Overflow: second row completes while the first is still pending
    for (int k = 0; k < 8; k++) send_plane(k, 4'd5, 8);
    check("no_overflow_first_row", 32'(overflow), 0);
    for (int k = 0; k < 8; k++) send_plane(7 - k, 4'd6, 8);
    check("overflow_set", 32'(overflow), 1);
    check("first_row_still_valid", 32'(bus.out_valid), 1);
    drain(4'd5, -1);
    check("overflow_sticky", 32'(overflow), 1);

    // Address change at plane 3 restarts the row at address 2
    do_reset();
    for (int k = 0; k < 3; k++) send_plane(k, 4'd1, 8);
    check("sync_err_before_addr_change", 32'(sync_err), 0);
    send_plane(3, 4'd2, 8);
    check("sync_err_addr_change", 32'(sync_err), 1);
    check("no_valid_after_restart", 32'(bus.out_valid), 0);
    for (int k = 1; k < 8; k++) send_plane(k, 4'd2, 8);
    check("valid_restarted_row", 32'(bus.out_valid), 1);
    set_diag_pixels();
    exp_pix[0] = 24'h000000;
    exp_pix[3] = 24'h090909;
    drain(4'd2, -1);
    check("no_overflow_restart", 32'(overflow), 0);

    // Short chain: 7 shifts before the latch
    do_reset();
    send_plane(0, 4'd4, 7);
`ifdef DISPLAY_PANEL_CAPTURE_LENGTH_CHECK_EN
    check("sync_err_short_chain", 32'(sync_err), 1);
`else
    check("sync_err_short_chain", 32'(sync_err), 0);
`endif
    check("no_valid_short_chain", 32'(bus.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
